// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state/cause encodings and constants for the run controller
package run_ctrl_pkg;
   typedef enum logic [1:0] {HALT = 2'b00, STEP = 2'b01, RUN = 2'b10, BREAK = 2'b11} run_state_t;
   typedef enum logic [1:0] {NONE = 2'b00, MANUAL = 2'b01, BREAKPT = 2'b10, EBREAK = 2'b11} halt_cause_t;
   localparam logic [31:0] EBREAK_WORD = 32'h00100073;
   localparam logic [1:0] RATE_SLOW = 2'b00;
   localparam logic [1:0] RATE_MED  = 2'b01;
   localparam logic [1:0] RATE_FAST = 2'b10;
   localparam logic [1:0] RATE_MAX  = 2'b11;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw input and accepts a level only after it has been stable
module button_debouncer #(
   parameter int unsigned DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic pulse
);
   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
   logic [1:0] sync_q;
   logic [CW-1:0] cnt_q;
   logic level_q, pulse_q;
   logic flip;
   assign flip  = (sync_q[1] != level_q) && (cnt_q == CW'(DEB_CYCLES - 1));
   assign level = level_q;
   assign pulse = pulse_q;
   // two-flop synchroniser, run-length counter of samples differing from the accepted level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn};
         cnt_q   <= (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
         level_q <= flip ? sync_q[1] : level_q;
         pulse_q <= flip && sync_q[1];
      end
   end
endmodule

// File: rtl/run_controller.sv
// run_controller: step/free-run sequencer producing a one-clock datapath enable
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 1000000,
   parameter int unsigned DIV_SLOW   = 50000000,
   parameter int unsigned DIV_MED    = 5000000,
   parameter int unsigned DIV_FAST   = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step_btn,
   input  logic        run_sw,
   input  logic [1:0]  rate_sel,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic [31:0] pc_value,
   input  logic [31:0] instruction,
   output logic        cpu_en,
   output logic [1:0]  run_state,
   output logic [1:0]  halt_cause,
   output logic [31:0] step_count
);
   logic step_pulse, run_lvl, step_lvl_unused, run_pulse_unused;
   run_state_t  state_q, state_d;
   halt_cause_t cause_q, cause_d;
   logic        en_q, en_d, skip_q, skip_d;
   logic [31:0] div_q, div_d, cnt_q, lim_m1;
   logic        tick, bp_hit;

   button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
      .clk(clk), .reset(reset), .btn(step_btn), .level(step_lvl_unused), .pulse(step_pulse)
   );
   button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
      .clk(clk), .reset(reset), .btn(run_sw), .level(run_lvl), .pulse(run_pulse_unused)
   );

   assign lim_m1 = rate_sel == RATE_MAX  ? 32'd0 :
                   rate_sel == RATE_SLOW ? 32'(DIV_SLOW - 1) :
                   rate_sel == RATE_MED  ? 32'(DIV_MED - 1) : 32'(DIV_FAST - 1);
   assign tick   = div_q >= lim_m1;
   assign bp_hit = bp_en && pc_value == bp_addr && !skip_q;

   // next-state decision; frozen while the datapath is being enabled so the PC is always current
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      en_d    = 1'b0;
      div_d   = div_q;
      skip_d  = skip_q;
      if (!en_q) begin
         case (state_q)
            HALT: begin
               if (step_pulse) state_d = STEP;
               else if (run_lvl) begin
                  state_d = RUN;
                  div_d   = '0;
                  skip_d  = 1'b1;
               end
            end
            STEP: begin
               en_d    = 1'b1;
               state_d = HALT;
               cause_d = NONE;
            end
            RUN: begin
               if (!run_lvl) begin
                  state_d = HALT;
                  cause_d = MANUAL;
               end else if (!tick) div_d = div_q + 32'd1;
               else begin
                  div_d = '0;
                  if (instruction == EBREAK_WORD) begin
                     state_d = BREAK;
                     cause_d = EBREAK;
                  end else if (bp_hit) begin
                     state_d = BREAK;
                     cause_d = BREAKPT;
                  end else begin
                     en_d   = 1'b1;
                     skip_d = 1'b0;
                  end
               end
            end
            default: begin
               if (step_pulse) state_d = STEP;
               else if (!run_lvl) state_d = HALT;
            end
         endcase
      end
   end

   // state registers and retired-step counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= HALT;
         cause_q <= NONE;
         en_q    <= 1'b0;
         div_q   <= '0;
         skip_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         en_q    <= en_d;
         div_q   <= div_d;
         skip_q  <= skip_d;
         cnt_q   <= cnt_q + 32'(en_q);
      end
   end

   assign cpu_en     = en_q;
   assign run_state  = state_q;
   assign halt_cause = cause_q;
   assign step_count = cnt_q;
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed and random stimulus against a behavioural model of the run controller
module tb_run_controller;
   localparam int DEB = 4;
   localparam logic [31:0] EBW = 32'h00100073;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0, reset = 1'b1, step_btn = 1'b0, run_sw = 1'b0, bp_en = 1'b0;
   logic [1:0] rate_sel = 2'd0;
   logic [31:0] bp_addr = 32'd0, pc_value, instruction;
   logic cpu_en;
   logic [1:0] run_state, halt_cause;
   logic [31:0] step_count;

   int checks = 0, errors = 0;
   bit chk_en = 1'b0;
   logic [31:0] mem [64];
   logic [31:0] pc = 32'd0, pc_mask = 32'hFF;
   logic [31:0] exec_q [$];
   logic prev_e = 1'b0;

   assign pc_value    = pc;
   assign instruction = mem[pc[7:2]];

   run_controller #(.DEB_CYCLES(DEB), .DIV_SLOW(8), .DIV_MED(4), .DIV_FAST(2)) dut (
      .clk(clk), .reset(reset), .step_btn(step_btn), .run_sw(run_sw), .rate_sel(rate_sel),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc_value(pc_value), .instruction(instruction),
      .cpu_en(cpu_en), .run_state(run_state), .halt_cause(halt_cause), .step_count(step_count)
   );

   always #5 clk = ~clk;

   // model: a button is accepted once the last DEB synchronised samples all disagree with the held level
   typedef struct packed {
      logic d1, d2, lvl, pulse;
      logic [DEB-1:0] win;
   } deb_t;

   int m_state, m_cause, m_wait;
   logic m_en, m_skip;
   logic [31:0] m_cnt;
   deb_t m_step, m_run;

   function automatic deb_t deb_next(deb_t d, logic btn);
      deb_t n = d;
      n.win = {d.win[DEB-2:0], d.d2};
      n.d2 = d.d1;
      n.d1 = btn;
      n.pulse = 1'b0;
      if (n.win == {DEB{~d.lvl}}) begin
         n.lvl = ~d.lvl;
         n.pulse = n.lvl;
      end
      return n;
   endfunction

   function automatic int period(logic [1:0] r);
      return r == 2'd0 ? 8 : r == 2'd1 ? 4 : r == 2'd2 ? 2 : 1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_cause = 0; m_wait = 0; m_en = 1'b0; m_skip = 1'b0; m_cnt = 32'd0;
      m_step = '0; m_run = '0;
   endtask

   // states: 0 halted, 1 single step, 2 free run, 3 stopped at break
   task automatic model_step();
      int ns, nc, nw;
      logic ne, nsk;
      if (!reset) begin
         model_reset();
         return;
      end
      ns = m_state; nc = m_cause; nw = m_wait; ne = 1'b0; nsk = m_skip;
      if (!m_en) begin
         if (m_state == 1) begin
            ne = 1'b1; ns = 0; nc = 0;
         end else if (m_state == 2) begin
            if (!m_run.lvl) begin
               ns = 0; nc = 1;
            end else if (m_wait + 1 < period(rate_sel)) nw = m_wait + 1;
            else begin
               nw = 0;
               if (instruction == EBW) begin ns = 3; nc = 3; end
               else if (bp_en && pc_value == bp_addr && !m_skip) begin ns = 3; nc = 2; end
               else begin ne = 1'b1; nsk = 1'b0; end
            end
         end else if (m_step.pulse) ns = 1;
         else if (m_state == 0 && m_run.lvl) begin ns = 2; nw = 0; nsk = 1'b1; end
         else if (m_state == 3 && !m_run.lvl) ns = 0;
      end
      m_cnt = m_cnt + 32'(m_en);
      m_state = ns; m_cause = nc; m_wait = nw; m_en = ne; m_skip = nsk;
      m_step = deb_next(m_step, step_btn);
      m_run = deb_next(m_run, run_sw);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cpu_en", 32'(cpu_en), 32'(m_en));
         chk("run_state", 32'(run_state), 32'(m_state));
         chk("halt_cause", 32'(halt_cause), 32'(m_cause));
         chk("step_count", step_count, m_cnt);
      end
   end

   task automatic tick();
      logic e;
      e = cpu_en;
      @(posedge clk);
      model_step();
      #1;
      if (e === 1'b1) begin
         chk("en_back_to_back", 32'(prev_e), 32'd0);
         exec_q.push_back(pc);
         pc = (pc + 32'd4) & pc_mask;
      end
      prev_e = e;
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_state(input logic [1:0] s, input int lim, input string nm);
      int n = 0;
      while (run_state !== s && n < lim) begin
         tick();
         n++;
      end
      chk(nm, 32'(run_state), 32'(s));
   endtask

   initial begin
      int n;
      logic [31:0] n0;
      for (int i = 0; i < 64; i++) mem[i] = NOP;
      model_reset();
      #1 reset = 1'b0;
      #1;
      chk("reset_cpu_en", 32'(cpu_en), 32'd0);
      chk("reset_state", 32'(run_state), 32'd0);
      chk("reset_cause", 32'(halt_cause), 32'd0);
      chk("reset_count", step_count, 32'd0);
      chk_en = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      // held step button gives one step
      step_btn = 1'b1;
      repeat (10) tick();
      step_btn = 1'b0;
      repeat (10) tick();
      chk("step_pulses", 32'(exec_q.size()), 32'd1);
      chk("step_count_1", step_count, 32'd1);
      chk("model_count_1", m_cnt, 32'd1);
      chk("step_cause", 32'(halt_cause), 32'd0);
      // bouncing button is rejected
      step_btn = 1'b1; tick();
      step_btn = 1'b0; tick();
      step_btn = 1'b1; tick();
      step_btn = 1'b0;
      repeat (12) tick();
      chk("bounce_count", step_count, 32'd1);
      // free run at max rate into a breakpoint
      do_reset();
      pc = 32'd0;
      exec_q.delete();
      bp_en = 1'b1; bp_addr = 32'h10; rate_sel = 2'd3; run_sw = 1'b1;
      wait_state(2'd3, 100, "bp_reached");
      chk("bp_exec_n", 32'(exec_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < exec_q.size(); i++) chk("bp_exec_pc", exec_q[i], 32'(i * 4));
      chk("bp_cause", 32'(halt_cause), 32'd2);
      chk("model_bp_cause", 32'(m_cause), 32'd2);
      chk("bp_count", step_count, 32'd4);
      chk("bp_pc", pc, 32'h10);
      // resume executes the breakpoint instruction once
      run_sw = 1'b0;
      wait_state(2'd0, 50, "bp_to_halt");
      chk("bp_cause_held", 32'(halt_cause), 32'd2);
      exec_q.delete();
      run_sw = 1'b1;
      n = 0;
      while (exec_q.size() < 2 && n < 100) begin tick(); n++; end
      chk("resume_exec_n", 32'(exec_q.size()), 32'd2);
      if (exec_q.size() >= 2) begin
         chk("resume_pc0", exec_q[0], 32'h10);
         chk("resume_pc1", exec_q[1], 32'h14);
      end
      // slow rate into an EBREAK
      rate_sel = 2'd0;
      mem[7] = EBW;
      wait_state(2'd3, 200, "ebreak_reached");
      chk("ebreak_cause", 32'(halt_cause), 32'd3);
      chk("ebreak_pc", pc, 32'h1C);
      chk("ebreak_no_en", 32'(cpu_en), 32'd0);
      // a step executes the EBREAK
      n0 = step_count;
      exec_q.delete();
      step_btn = 1'b1;
      n = 0;
      while (step_count !== n0 + 32'd1 && n < 30) begin tick(); n++; end
      chk("ebreak_step_count", step_count, n0 + 32'd1);
      chk("ebreak_step_cause", 32'(halt_cause), 32'd0);
      chk("ebreak_step_n", 32'(exec_q.size()), 32'd1);
      if (exec_q.size() > 0) chk("ebreak_step_pc", exec_q[0], 32'h1C);
      step_btn = 1'b0;
      // manual stop mid-count
      repeat (3) tick();
      run_sw = 1'b0;
      wait_state(2'd0, 50, "manual_halt");
      chk("manual_cause", 32'(halt_cause), 32'd1);
      n0 = step_count;
      repeat (30) tick();
      chk("manual_no_en", step_count, n0);
      // randomized phase
      pc_mask = 32'h3F;
      pc = pc & pc_mask;
      for (int i = 0; i < 16; i++) mem[i] = ($urandom_range(0, 7) == 0) ? EBW : NOP;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
         if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
         if ($urandom_range(0, 99) == 0) rate_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 199) == 0) begin
            bp_en = 1'($urandom_range(0, 1));
            bp_addr = 32'($urandom_range(0, 15)) << 2;
         end
         if ($urandom_range(0, 149) == 0) mem[$urandom_range(0, 15)] = ($urandom_range(0, 2) == 0) ? EBW : NOP;
         if ($urandom_range(0, 999) == 0) do_reset();
         else tick();
      end
      // reset during an enable cycle
      for (int i = 0; i < 64; i++) mem[i] = NOP;
      bp_en = 1'b0; step_btn = 1'b0; rate_sel = 2'd3; run_sw = 1'b0;
      repeat (12) tick();
      run_sw = 1'b1;
      n = 0;
      while (cpu_en !== 1'b1 && n < 100) begin tick(); n++; end
      chk("final_en_seen", 32'(cpu_en), 32'd1);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("midpulse_cpu_en", 32'(cpu_en), 32'd0);
      chk("midpulse_count", step_count, 32'd0);
      chk("midpulse_state", 32'(run_state), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      repeat (3) tick();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
